uart_rx_frame: RTL
==================

# uart_rx_frame

Serial receive path of the UART: the counterpart to the transmit path. It oversamples the serial line at 16× the selected baud rate, detects and qualifies the start bit, and samples each data bit at mid-bit. It checks optional parity and the stop bit, then presents the received byte with a one-cycle done strobe. It sits between the external RxIn pin and the receive-side consumer logic, and runs on the same system clock and baud-select encoding as the transmitter.

## Interface
- CLK_HZ, 50_000_000, system clock frequency; the oversample divisors in the package are derived for this value.
- DATA_BITS, 8, data bits per frame, sent LSB first.

- Clock  in  1  system clock; all logic is on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- RxIn  in  1  serial line; idles high; asynchronous to Clock.
- BaudRate  in  2  baud select: 00 = 2400, 01 = 4800, 10 = 9600, 11 = 19200.
- ParityEn  in  1  1 = a parity bit follows the data bits.
- ParityOdd  in  1  0 = even parity, 1 = odd parity; ignored when ParityEn = 0.
- RxData  out  DATA_BITS  last received byte.
- RxDone  out  1  one-cycle strobe: frame complete, RxData/ParityError/StopError valid.
- ParityError  out  1  parity mismatch in the last frame.
- StopError  out  1  stop bit sampled low in the last frame (framing error).
- RxBusy  out  1  high while a frame is in progress (state ≠ IDLE).

## Operation
- RxIn passes through a 2-flop synchronizer (reset value 1). All logic uses the synchronized value RxS.
- Oversample tick generator:
  - counts 0..DIV-1 and pulses Tick for one cycle at DIV-1.
  - DIV per BaudRate: 1302, 651, 326, 163.
  - The counter is held at 0 in IDLE.
  - BaudRate, ParityEn and ParityOdd are latched on the IDLE→START transition. Changes mid-frame have no effect.
- Within a state, TickCnt (4 bits) counts ticks. BitCnt (3 bits) counts data bits.
- FSM states:
  - IDLE: when RxS = 0 → START, with TickCnt = 0.
  - START: on the 8th tick (mid start bit), sample RxS.
    - RxS = 1 → IDLE (glitch rejected; no strobe, outputs unchanged).
    - RxS = 0 → DATA, with TickCnt = 0 and BitCnt = 0.
  - DATA: every 16th tick, shift RxS into bit position BitCnt (LSB first).
    - After bit DATA_BITS-1: → PARITY if ParityEn, else → STOP.
  - PARITY: on the 16th tick, sample the parity bit.
    - Expected bit = XOR(data) XOR ParityOdd.
    - Hold the mismatch in an internal flag.
  - STOP: on the 16th tick, sample the stop bit.
    - RxData, ParityError (the flag, forced 0 if ParityEn = 0) and StopError (= ~RxS) all update in the same cycle.
    - RxDone pulses in that cycle.
    - → IDLE.
- A frame with StopError still delivers its data and strobe.
- Back-to-back frames: IDLE is re-entered mid stop bit. The next falling edge is accepted immediately.
- A line held low (break) gives StopError = 1, then re-arms from IDLE. RxS is still 0, so a new START begins at once.

## Timing
- Reset values: RxData = 0, RxDone = 0, ParityError = 0, StopError = 0, RxBusy = 0, state = IDLE, synchronizer = 1.
- Reset is asynchronous at any point, including mid-frame: the FSM returns to IDLE, counters clear, and no strobe is produced.
- Bit period = 16 × DIV clocks; at 19200 baud this is 2608 clocks.
- Detection latency: the RxIn fall appears on RxS 2 clocks later. START is entered on the following edge.
- Sample points: start bit at 8 ticks; data bit k at 8 + 16(k+1) ticks after START entry; stop bit 16 ticks after the last data or parity sample.
- RxDone asserts in the same cycle RxData updates. It stays high exactly 1 clock.
- The error outputs hold their values until the next RxDone.

## Structure
- Shared package uart_pkg:
  - baud select codes and the DIV lookup function;
  - rx state enum (IDLE, START, DATA, PARITY, STOP);
  - OVERSAMPLE = 16.
- One sub-module: uart_rx_tick_gen.
  - Inputs: Clock, Reset, Enable, BaudRate.
  - Output: Tick.
  - Clears its count when Enable = 0.
- The FSM, shift register and synchronizer stay in uart_rx_frame.

## Test plan
- 19200 baud, no parity, send 0xA5 with a good stop bit → one RxDone pulse, RxData = 0xA5, both errors 0. Done occurs ~9.5 bit periods after the start edge, within ±2 clocks.
- 9600 baud, even parity, send 0x3C with parity bit 1 → ParityError = 1 at RxDone. Then send 0x3C with parity bit 0 → ParityError = 0.
- 2400 baud, send 0x55 with the stop bit driven low → RxDone pulses, RxData = 0x55, StopError = 1.
- RxIn low pulse of 3 ticks, then high → FSM returns to IDLE, no RxDone, RxBusy drops.
- 19200 baud, back-to-back frames 0x00, 0xFF, 0x81 with no idle gap → three RxDone pulses carrying the correct values in order.
- Assert Reset during DATA bit 4 → all outputs 0 immediately. A following clean frame 0x12 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud select codes, oversample divisor lookup
// and the receive state encoding.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DIV_W      = 16;

    localparam logic [1:0] BAUD_2400  = 2'b00;
    localparam logic [1:0] BAUD_4800  = 2'b01;
    localparam logic [1:0] BAUD_9600  = 2'b10;
    localparam logic [1:0] BAUD_19200 = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // Rounded clk_hz / (baud * 16); gives 1302/651/326/163 at 50 MHz.
    function automatic logic [DIV_W-1:0] div_of(input int clk_hz, input int baud);
        return DIV_W'((clk_hz + baud * (OVERSAMPLE / 2)) / (baud * OVERSAMPLE));
    endfunction

    function automatic logic [DIV_W-1:0] baud_div(input logic [1:0] sel, input int clk_hz);
        logic [DIV_W-1:0] div;
        case (sel)
            BAUD_2400:  div = div_of(clk_hz, 2400);
            BAUD_4800:  div = div_of(clk_hz, 4800);
            BAUD_9600:  div = div_of(clk_hz, 9600);
            BAUD_19200: div = div_of(clk_hz, 19200);
            default:    div = div_of(clk_hz, 2400);
        endcase
        return div;
    endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Receive-side signal bundle: line and frame configuration in, byte and
// status out. The slave modport is the receiver's view.
interface uart_rx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic                 RxIn;
    logic [1:0]           BaudRate;
    logic                 ParityEn;
    logic                 ParityOdd;
    logic [DATA_BITS-1:0] RxData;
    logic                 RxDone;
    logic                 ParityError;
    logic                 StopError;
    logic                 RxBusy;

    modport master (
        output RxIn, BaudRate, ParityEn, ParityOdd,
        input  RxData, RxDone, ParityError, StopError, RxBusy
    );

    modport slave (
        input  RxIn, BaudRate, ParityEn, ParityOdd,
        output RxData, RxDone, ParityError, StopError, RxBusy
    );
endinterface

// File: rtl/uart_rx_tick_gen.sv
// 16x oversample tick generator; counts 0..DIV-1 while enabled and
// pulses Tick on the last count.
module uart_rx_tick_gen
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Enable,
    input  logic [1:0] BaudRate,
    output logic       Tick
);
    localparam logic [DIV_W-1:0] DIV_2400  = baud_div(BAUD_2400, CLK_HZ);
    localparam logic [DIV_W-1:0] DIV_4800  = baud_div(BAUD_4800, CLK_HZ);
    localparam logic [DIV_W-1:0] DIV_9600  = baud_div(BAUD_9600, CLK_HZ);
    localparam logic [DIV_W-1:0] DIV_19200 = baud_div(BAUD_19200, CLK_HZ);

    logic [DIV_W-1:0] div_s;
    logic [DIV_W-1:0] cnt_r;

    // Divisor selection
    always_comb begin
        case (BaudRate)
            BAUD_2400:  div_s = DIV_2400;
            BAUD_4800:  div_s = DIV_4800;
            BAUD_9600:  div_s = DIV_9600;
            BAUD_19200: div_s = DIV_19200;
            default:    div_s = DIV_2400;
        endcase
    end

    assign Tick = Enable && (cnt_r == (div_s - {{(DIV_W-1){1'b0}}, 1'b1}));

    // Oversample counter, held at zero while disabled
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt_r <= {DIV_W{1'b0}};
        end else if (!Enable || Tick) begin
            cnt_r <= {DIV_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive path: synchronizes RxIn, qualifies the start bit, samples
// data/parity/stop at mid-bit and strobes RxDone with the received byte.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int DATA_BITS = 8
) (
    input logic            Clock,
    input logic            Reset,
    uart_rx_frame_if.slave rx
);
    localparam int               BIT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
    localparam logic [3:0]       TICK_MID = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]       TICK_END = 4'(OVERSAMPLE - 1);

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

    logic [1:0]           sync_r;
    logic                 rxs_s;
    logic                 tick_s;
    logic                 tick_en_s;
    rx_state_e            state_r, state_nxt_s;

    logic [3:0]           tick_cnt_r, tick_cnt_nxt_s;
    logic [BIT_W-1:0]     bit_cnt_r, bit_cnt_nxt_s;
    logic [DATA_BITS-1:0] shift_r, shift_nxt_s;
    logic                 par_flag_r, par_flag_nxt_s;
    logic [1:0]           baud_r, baud_nxt_s;
    logic                 par_en_r, par_en_nxt_s;
    logic                 par_odd_r, par_odd_nxt_s;
    logic [DATA_BITS-1:0] rx_data_r, rx_data_nxt_s;
    logic                 done_r, done_nxt_s;
    logic                 perr_r, perr_nxt_s;
    logic                 serr_r, serr_nxt_s;
    logic                 busy_r;

    // Two-flop synchronizer for the asynchronous serial line
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], rx.RxIn};
        end
    end

    assign rxs_s     = sync_r[1];
    assign tick_en_s = (state_r != IDLE);

    uart_rx_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick_gen (
        .Clock    (Clock),
        .Reset    (Reset),
        .Enable   (tick_en_s),
        .BaudRate (baud_r),
        .Tick     (tick_s)
    );

    // FSM state register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (!rxs_s) state_nxt_s = START;
                else        state_nxt_s = IDLE;
            end
            START: begin
                if (tick_s && (tick_cnt_r == TICK_MID)) state_nxt_s = rxs_s ? IDLE : DATA;
                else                                    state_nxt_s = START;
            end
            DATA: begin
                if (tick_s && (tick_cnt_r == TICK_END) && (bit_cnt_r == LAST_BIT))
                    state_nxt_s = par_en_r ? PARITY : STOP;
                else
                    state_nxt_s = DATA;
            end
            PARITY: begin
                if (tick_s && (tick_cnt_r == TICK_END)) state_nxt_s = STOP;
                else                                    state_nxt_s = PARITY;
            end
            STOP: begin
                if (tick_s && (tick_cnt_r == TICK_END)) state_nxt_s = IDLE;
                else                                    state_nxt_s = STOP;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output / datapath next values
    always_comb begin
        tick_cnt_nxt_s = tick_cnt_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        shift_nxt_s    = shift_r;
        par_flag_nxt_s = par_flag_r;
        baud_nxt_s     = baud_r;
        par_en_nxt_s   = par_en_r;
        par_odd_nxt_s  = par_odd_r;
        rx_data_nxt_s  = rx_data_r;
        done_nxt_s     = 1'b0;
        perr_nxt_s     = perr_r;
        serr_nxt_s     = serr_r;
        case (state_r)
            IDLE: begin
                tick_cnt_nxt_s = 4'd0;
                bit_cnt_nxt_s  = {BIT_W{1'b0}};
                // Frame configuration is frozen for the whole frame
                if (!rxs_s) begin
                    baud_nxt_s     = rx.BaudRate;
                    par_en_nxt_s   = rx.ParityEn;
                    par_odd_nxt_s  = rx.ParityOdd;
                    par_flag_nxt_s = 1'b0;
                end else begin
                    par_flag_nxt_s = par_flag_r;
                end
            end
            START: begin
                if (tick_s && (tick_cnt_r == TICK_MID)) begin
                    tick_cnt_nxt_s = 4'd0;
                    bit_cnt_nxt_s  = {BIT_W{1'b0}};
                end else if (tick_s) begin
                    tick_cnt_nxt_s = tick_cnt_r + 4'd1;
                end else begin
                    tick_cnt_nxt_s = tick_cnt_r;
                end
            end
            DATA: begin
                if (tick_s && (tick_cnt_r == TICK_END)) begin
                    shift_nxt_s[bit_cnt_r] = rxs_s;
                    tick_cnt_nxt_s         = 4'd0;
                    bit_cnt_nxt_s          = bit_cnt_r + {{(BIT_W-1){1'b0}}, 1'b1};
                end else if (tick_s) begin
                    tick_cnt_nxt_s = tick_cnt_r + 4'd1;
                end else begin
                    tick_cnt_nxt_s = tick_cnt_r;
                end
            end
            PARITY: begin
                if (tick_s && (tick_cnt_r == TICK_END)) begin
                    par_flag_nxt_s = rxs_s ^ (parity_of(shift_r) ^ par_odd_r);
                    tick_cnt_nxt_s = 4'd0;
                end else if (tick_s) begin
                    tick_cnt_nxt_s = tick_cnt_r + 4'd1;
                end else begin
                    tick_cnt_nxt_s = tick_cnt_r;
                end
            end
            STOP: begin
                if (tick_s && (tick_cnt_r == TICK_END)) begin
                    rx_data_nxt_s  = shift_r;
                    perr_nxt_s     = par_en_r & par_flag_r;
                    serr_nxt_s     = ~rxs_s;
                    done_nxt_s     = 1'b1;
                    tick_cnt_nxt_s = 4'd0;
                end else if (tick_s) begin
                    tick_cnt_nxt_s = tick_cnt_r + 4'd1;
                end else begin
                    tick_cnt_nxt_s = tick_cnt_r;
                end
            end
            default: begin
                tick_cnt_nxt_s = 4'd0;
                bit_cnt_nxt_s  = {BIT_W{1'b0}};
            end
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            tick_cnt_r <= 4'd0;
            bit_cnt_r  <= {BIT_W{1'b0}};
            shift_r    <= {DATA_BITS{1'b0}};
            par_flag_r <= 1'b0;
            baud_r     <= 2'b00;
            par_en_r   <= 1'b0;
            par_odd_r  <= 1'b0;
            rx_data_r  <= {DATA_BITS{1'b0}};
            done_r     <= 1'b0;
            perr_r     <= 1'b0;
            serr_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            tick_cnt_r <= tick_cnt_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            shift_r    <= shift_nxt_s;
            par_flag_r <= par_flag_nxt_s;
            baud_r     <= baud_nxt_s;
            par_en_r   <= par_en_nxt_s;
            par_odd_r  <= par_odd_nxt_s;
            rx_data_r  <= rx_data_nxt_s;
            done_r     <= done_nxt_s;
            perr_r     <= perr_nxt_s;
            serr_r     <= serr_nxt_s;
            busy_r     <= (state_nxt_s != IDLE);
        end
    end

    assign rx.RxData      = rx_data_r;
    assign rx.RxDone      = done_r;
    assign rx.ParityError = perr_r;
    assign rx.StopError   = serr_r;
    assign rx.RxBusy      = busy_r;

endmodule
